ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder on the far side of the CPU's bus master: zero- or fixed-wait-state SRAM
//  slave serving instruction fetch, load/store and AMO traffic from the prv332sv0 BIU.
//  Decodes one window of the 34-bit physical space, holds a word-organised register array,
//  and returns OKAY or ERROR responses with the AHB-Lite data-phase handshake.
// PARAMETERS
//  BASE_ADDR    34'h0_8000_0000  byte base of the decoded window (DEPTH*4-aligned)
//  DEPTH        1024             number of 32-bit words (power of two, >=4)
//  WAIT_STATES  0                data-phase wait cycles per transfer (0..15)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  hreset_n   in   1   asynchronous active-low reset
//  hsel       in   1   slave select from address decoder
//  haddr      in   34  byte address (address phase)
//  htrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite     in   1   1 = write
//  hsize      in   2   00 byte, 01 half, 10 word, 11 reserved
//  hburst     in   3   ignored (each beat handled as single)
//  hprot      in   4   ignored
//  hmastlock  in   1   ignored (single-ported array; AMO read/write pairs are atomic already)
//  hwdata     in   32  write data (data phase)
//  hready     in   1   bus-wide ready; address phase accepted only when 1
//  hreadyout  out  1   slave ready for current data phase
//  hresp      out  1   0 OKAY, 1 ERROR
//  hrdata     out  32  read data, whole aligned word, valid when hreadyout=1 and read
// BEHAVIOUR
//  - Reset: state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter 0; array contents undefined.
//  - Accept: hsel & hready & htrans[1] at rising edge -> latch addr/size/write, load wait counter
//    with WAIT_STATES. IDLE/BUSY or !hsel -> no transfer, next data phase hreadyout=1, hresp=0.
//  - FSM: IDLE -> WAIT (WAIT_STATES>0) or DATA (=0); WAIT counts down, hreadyout=0, hresp=0,
//    to DATA when count reaches 1; DATA drives hreadyout=1, hresp=0 for one cycle, then
//    IDLE or directly into next accepted transfer (pipelined back-to-back, no bubble).
//  - Latency: WAIT_STATES=0 -> every transfer completes in 1 data-phase cycle; N -> N+1 cycles.
//  - Read: hrdata = array[latched word index] during DATA cycle; hrdata holds last value otherwise.
//  - Write: byte lanes enabled from latched hsize and addr[1:0] (little-endian); hwdata sampled
//    and array updated at the rising edge closing the DATA cycle. Write then read of same word
//    back-to-back returns the new data (read sources array in its own data phase).
//  - Word index = (addr - BASE_ADDR)[log2(DEPTH)+1:2]; window wraps nowhere - see errors.
//  - New address phase presented while WAIT is active is ignored (hready=0 on bus).
//  - Reset asserted mid-transfer: transfer aborted, no array write committed.
// CONFIGURATION
//  AHB_SRAM_ERR_CHK_EN defined: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH-1], misaligned
//    access (half with addr[0]=1, word with addr[1:0]!=0) or hsize=11 -> two-cycle ERROR:
//    ERR1 hreadyout=0 hresp=1, ERR2 hreadyout=1 hresp=1, then IDLE; no write, hrdata unchanged.
//    Wait states are skipped for erroring transfers.
//  Not defined: no checks; index uses low address bits only (window aliases), misaligned
//    accesses use the aligned word with lanes from addr[1:0] and hsize, always OKAY.
// TESTING
//  1. WAIT_STATES=0: NONSEQ word write 0x8000_0010 <- 0xDEADBEEF, next cycle read same ->
//     hreadyout=1 every cycle, hrdata=0xDEADBEEF, hresp=0.
//  2. Byte write 0x8000_0013 <- hwdata 0xAA00_0000 over 0x1122_3344 -> read 0xAA22_3344;
//     half write 0x8000_0012 <- 0x5566_0000 -> read 0x5566_3344.
//  3. WAIT_STATES=3: single read -> hreadyout low exactly 3 cycles, high 1 cycle with data.
//  4. ERR_CHK_EN, word read at 0x8000_0002 and write at BASE+4*DEPTH -> hresp=1 with
//     hreadyout 0 then 1; follow-up read of target word shows no change.
//  5. 4-beat SEQ burst of writes then reads, IDLE/BUSY interleaved -> no bubbles on
//     NONSEQ/SEQ, OKAY zero-wait on IDLE/BUSY, data matches.
//  6. hreset_n pulsed low during WAIT of a write -> outputs return to reset values
//     asynchronously; word not modified.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised array behind one decoded window, optional wait states.
// Define AHB_SRAM_ERR_CHK_EN to enable range/alignment/size checking with two-cycle ERROR responses.
module ahb_sram_slave #(
  parameter logic [33:0] BASE_ADDR   = 34'h0_8000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [33:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [1:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int        AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            lat_write;
  logic [AW-1:0]   lat_idx;
  logic [3:0]      lat_lanes;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            bad;
  logic [33:0]     offset;
  logic [AW-1:0]   new_idx;
  logic [AW-1:0]   rd_idx;
  logic            wr_commit;
  logic [31:0]     wr_word;
  logic [31:0]     rd_word;
  logic            unused_ok;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_mask = 4'b0001 << a;
      2'b01:   lane_mask = 4'b0011 << a;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] lanes);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (lanes[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign accept  = hsel & hready & htrans[1] & hreadyout;
  assign offset  = haddr - BASE_ADDR;
  assign new_idx = offset[AW+1:2];

`ifdef AHB_SRAM_ERR_CHK_EN
  localparam logic [34:0] LIMIT = {1'b0, BASE_ADDR} + 35'(4 * DEPTH);
  assign bad = (haddr < BASE_ADDR) || ({1'b0, haddr} >= LIMIT) || (hsize == 2'b11) ||
               ((hsize == 2'b01) && haddr[0]) || ((hsize == 2'b10) && (haddr[1:0] != 2'b00));
`else
  assign bad = 1'b0;
`endif

  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], offset[33:AW+2], offset[1:0]};

  // A write commits at the same edge a following read loads hrdata, so forward the merged word.
  assign wr_commit = (state == ST_DATA) && lat_write;
  assign wr_word   = merge_lanes(mem[lat_idx], hwdata, lat_lanes);
  assign rd_idx    = (state == ST_WAIT) ? lat_idx : new_idx;
  assign rd_word   = (wr_commit && (lat_idx == rd_idx)) ? wr_word : mem[rd_idx];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (wr_commit && lat_lanes[b]) mem[lat_idx][8*b +: 8] <= hwdata[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_idx   <= new_idx;
      lat_lanes <= lane_mask(hsize, haddr[1:0]);
    end
  end

  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= 32'h0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == 4'd1) begin
            state     <= ST_DATA;
            hreadyout <= 1'b1;
            if (!lat_write) hrdata <= rd_word;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end
        default: begin
          if (accept) begin
            lat_write <= hwrite & ~bad;
            if (bad) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
            end else if (WS == 4'd0) begin
              state     <= ST_DATA;
              hreadyout <= 1'b1;
              hresp     <= 1'b0;
              if (!hwrite) hrdata <= rd_word;
            end else begin
              state     <= ST_WAIT;
              cnt       <= WS;
              hreadyout <= 1'b0;
              hresp     <= 1'b0;
            end
          end else begin
            state     <= ST_IDLE;
            lat_write <= 1'b0;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
